// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code consumer: pops bytes from the keyboard FIFO, strips E0/F0 prefixes and emits make/break events.
// Optional build macro KBD_TYPEMATIC_FILTER_EN suppresses events for typematic repeats of the held key.
module ps2_key_event_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_repeat,
  output logic             key_held,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] press_count,
  output logic             proto_err,
  output logic             ovf_seen
);

  typedef enum logic {FETCH = 1'b0, POP = 1'b1} state_t;

  state_t           r_state;
  logic             r_nextdata_n;
  logic             r_ext_pend;
  logic             r_brk_pend;
  logic             r_key_valid;
  logic [7:0]       r_key_code;
  logic             r_key_ext;
  logic             r_key_break;
  logic             r_key_repeat;
  logic             r_key_held;
  logic [7:0]       r_held_code;
  logic             r_held_ext;
  logic [CNT_W-1:0] r_press_count;
  logic             r_proto_err;
  logic             r_ovf_seen;

  logic w_is_e0;
  logic w_is_f0;
  logic w_is_proto;
  logic w_match_held;

  assign w_is_e0    = (ps2_data == 8'hE0);
  assign w_is_f0    = (ps2_data == 8'hF0);
  assign w_is_proto = (ps2_data == 8'hAA) || (ps2_data == 8'hFA) || (ps2_data == 8'hEE) ||
                      (ps2_data == 8'hFE) || (ps2_data == 8'h00) || (ps2_data == 8'hFF);
  // Identity of a key is the code together with its extended flag.
  assign w_match_held = r_key_held && (ps2_data == r_held_code) && (r_ext_pend == r_held_ext);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= FETCH;
      r_nextdata_n  <= 1'b1;
      r_ext_pend    <= 1'b0;
      r_brk_pend    <= 1'b0;
      r_key_valid   <= 1'b0;
      r_key_code    <= 8'h00;
      r_key_ext     <= 1'b0;
      r_key_break   <= 1'b0;
      r_key_repeat  <= 1'b0;
      r_key_held    <= 1'b0;
      r_held_code   <= 8'h00;
      r_held_ext    <= 1'b0;
      r_press_count <= '0;
      r_proto_err   <= 1'b0;
      r_ovf_seen    <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (ps2_overflow) r_ovf_seen <= 1'b1;

      case (r_state)
        FETCH: begin
          if (ps2_ready) begin
            r_nextdata_n <= 1'b0;
            r_state      <= POP;
            if (w_is_e0) begin
              if (r_ext_pend || r_brk_pend) r_proto_err <= 1'b1;
              else                          r_ext_pend  <= 1'b1;
            end else if (w_is_f0) begin
              if (r_brk_pend) begin
                r_proto_err <= 1'b1;
                r_ext_pend  <= 1'b0;
              end else begin
                r_brk_pend  <= 1'b1;
              end
            end else if (!(w_is_proto && !r_ext_pend && !r_brk_pend)) begin
              r_ext_pend <= 1'b0;
              r_brk_pend <= 1'b0;
              if (r_brk_pend) begin
                r_key_valid  <= 1'b1;
                r_key_code   <= ps2_data;
                r_key_ext    <= r_ext_pend;
                r_key_break  <= 1'b1;
                r_key_repeat <= 1'b0;
                if (w_match_held) begin
                  r_key_held  <= 1'b0;
                  r_held_code <= 8'h00;
                  r_held_ext  <= 1'b0;
                end
              end else if (w_match_held) begin
`ifndef KBD_TYPEMATIC_FILTER_EN
                r_key_valid  <= 1'b1;
                r_key_code   <= ps2_data;
                r_key_ext    <= r_ext_pend;
                r_key_break  <= 1'b0;
                r_key_repeat <= 1'b1;
`endif
              end else begin
                r_key_valid   <= 1'b1;
                r_key_code    <= ps2_data;
                r_key_ext     <= r_ext_pend;
                r_key_break   <= 1'b0;
                r_key_repeat  <= 1'b0;
                r_key_held    <= 1'b1;
                r_held_code   <= ps2_data;
                r_held_ext    <= r_ext_pend;
                r_press_count <= r_press_count + CNT_W'(1);
              end
            end
          end
        end
        POP: begin
          // Head byte is stale this cycle; never sample here.
          r_nextdata_n <= 1'b1;
          r_state      <= FETCH;
        end
        default: begin
          r_nextdata_n <= 1'b1;
          r_state      <= FETCH;
        end
      endcase
    end
  end

  assign nextdata_n  = r_nextdata_n;
  assign key_valid   = r_key_valid;
  assign key_code    = r_key_code;
  assign key_ext     = r_key_ext;
  assign key_break   = r_key_break;
  assign key_repeat  = r_key_repeat;
  assign key_held    = r_key_held;
  assign held_code   = r_held_code;
  assign press_count = r_press_count;
  assign proto_err   = r_proto_err;
  assign ovf_seen    = r_ovf_seen;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Self-checking bench for ps2_key_event_decoder: byte streams checked against a key-event reference model.
module tb_ps2_key_event_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       ps2_overflow = 1'b0;
  logic       nextdata_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_repeat;
  logic       key_held;
  logic [7:0] held_code;
  logic [7:0] press_count;
  logic       proto_err;
  logic       ovf_seen;

  ps2_key_event_decoder #(.CNT_W(8)) dut (
    .clock(clock), .reset(reset), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_overflow(ps2_overflow), .nextdata_n(nextdata_n), .key_valid(key_valid),
    .key_code(key_code), .key_ext(key_ext), .key_break(key_break), .key_repeat(key_repeat),
    .key_held(key_held), .held_code(held_code), .press_count(press_count),
    .proto_err(proto_err), .ovf_seen(ovf_seen)
  );

  always #5 clock = ~clock;

`ifdef KBD_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  typedef struct packed {
    logic       kv;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic       held;
    logic [7:0] hcode;
    logic [7:0] cnt;
    logic       perr;
    logic       ovf;
  } obs_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: visible outputs plus pending prefixes and the held key's ext flag.
  obs_t m;
  bit   m_ext_p, m_brk_p, m_hext;

  function automatic obs_t snap();
    obs_t s;
    s = '{key_valid, key_code, key_ext, key_break, key_repeat, key_held, held_code,
          press_count, proto_err, ovf_seen};
    return s;
  endfunction

  function void model_reset();
    m = '0;
    m_ext_p = 0; m_brk_p = 0; m_hext = 0;
  endfunction

  function void model_byte(input logic [7:0] b);
    bit same;
    m.kv = 1'b0;
    if (b == 8'hE0) begin
      if (m_ext_p || m_brk_p) m.perr = 1'b1; else m_ext_p = 1;
    end else if (b == 8'hF0) begin
      if (m_brk_p) begin m.perr = 1'b1; m_ext_p = 0; end else m_brk_p = 1;
    end else if ((b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) && !m_ext_p && !m_brk_p) begin
      m.kv = 1'b0;
    end else begin
      same = m.held && (m.hcode == b) && (m_hext == m_ext_p);
      if (m_brk_p) begin
        m.kv = 1; m.code = b; m.ext = m_ext_p; m.brk = 1; m.rep = 0;
        if (same) begin m.held = 0; m.hcode = 8'h00; m_hext = 0; end
      end else if (same) begin
        if (!FILT) begin m.kv = 1; m.code = b; m.ext = m_ext_p; m.brk = 0; m.rep = 1; end
      end else begin
        m.kv = 1; m.code = b; m.ext = m_ext_p; m.brk = 0; m.rep = 0;
        m.held = 1; m.hcode = b; m_hext = m_ext_p; m.cnt = m.cnt + 8'd1;
      end
      m_ext_p = 0; m_brk_p = 0;
    end
  endfunction

  // Present one byte at the FIFO head; return outputs in the pop cycle, key_valid one cycle later,
  // and how many cycles the capture took (20 means the handshake never came).
  task automatic send_byte(input logic [7:0] b, output obs_t o, output logic kv_after, output int wc);
    ps2_data  = b;
    ps2_ready = 1'b1;
    wc = 0;
    do begin
      @(negedge clock);
      wc++;
    end while (nextdata_n !== 1'b0 && wc < 20);
    o = snap();
    @(negedge clock);
    kv_after  = key_valid;
    ps2_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; ps2_ready = 1'b0; ps2_overflow = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    obs_t zero = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_vec++;
    if (nextdata_n !== 1'b1) begin n_err++; $display("FAIL reset_nextdata_n got %b want 1", nextdata_n); end
    n_vec++;
    if (snap() !== zero) begin n_err++; $display("FAIL reset_outputs got %h want %h", snap(), zero); end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_vec++;
      if (nextdata_n !== 1'b1) begin n_err++; $display("FAIL idle_no_pop cyc %0d got %b want 1", i, nextdata_n); end
    end
  endtask

  task automatic test_make_break();
    logic [7:0] seq [3] = '{8'h1C, 8'hF0, 8'h1C};
    obs_t o; logic kva; int wc; int cyc = 0;
    do_reset();
    foreach (seq[i]) begin
      send_byte(seq[i], o, kva, wc);
      model_byte(seq[i]);
      cyc += wc + 1;
      n_vec++;
      if (o !== m) begin n_err++; $display("FAIL make_break byte %0d got %h want %h", i, o, m); end
      n_vec++;
      if (kva !== 1'b0) begin n_err++; $display("FAIL make_break_pulse byte %0d got %b want 0", i, kva); end
      if (i == 0) begin
        n_vec++;
        if (o.cnt !== 8'd1 || o.hcode !== 8'h1C || o.held !== 1'b1)
          begin n_err++; $display("FAIL make_held got cnt=%h held=%b code=%h want 01 1 1c", o.cnt, o.held, o.hcode); end
      end
    end
    n_vec++;
    if (held_code !== 8'h00 || key_held !== 1'b0)
      begin n_err++; $display("FAIL break_release got held=%b code=%h want 0 00", key_held, held_code); end
    n_vec++;
    if (cyc != 6) begin n_err++; $display("FAIL make_break_cycles got %0d want 6", cyc); end
  endtask

  task automatic test_extended();
    logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    obs_t o; logic kva; int wc;
    do_reset();
    foreach (seq[i]) begin
      send_byte(seq[i], o, kva, wc);
      model_byte(seq[i]);
      n_vec++;
      if (o !== m) begin n_err++; $display("FAIL extended byte %0d got %h want %h", i, o, m); end
    end
    n_vec++;
    if (key_ext !== 1'b1 || key_break !== 1'b1 || press_count !== 8'd1 || proto_err !== 1'b0)
      begin n_err++; $display("FAIL extended_final got ext=%b brk=%b cnt=%h perr=%b want 1 1 01 0",
                              key_ext, key_break, press_count, proto_err); end
  endtask

  task automatic test_typematic();
    logic [7:0] seq [5] = '{8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B};
    obs_t o; logic kva; int wc; int ev = 0; int reps = 0;
    do_reset();
    foreach (seq[i]) begin
      send_byte(seq[i], o, kva, wc);
      model_byte(seq[i]);
      if (o.kv) ev++;
      if (o.kv && o.rep) reps++;
      n_vec++;
      if (o !== m) begin n_err++; $display("FAIL typematic byte %0d got %h want %h", i, o, m); end
    end
    n_vec++;
    if (ev != (FILT ? 2 : 4)) begin n_err++; $display("FAIL typematic_events got %0d want %0d", ev, FILT ? 2 : 4); end
    n_vec++;
    if (reps != (FILT ? 0 : 2)) begin n_err++; $display("FAIL typematic_repeats got %0d want %0d", reps, FILT ? 0 : 2); end
    n_vec++;
    if (press_count !== 8'd1) begin n_err++; $display("FAIL typematic_count got %h want 01", press_count); end
  endtask

  task automatic test_protocol();
    logic [7:0] seq [4] = '{8'hF0, 8'hF0, 8'h1C, 8'hAA};
    obs_t o; logic kva; int wc; int ev = 0;
    do_reset();
    foreach (seq[i]) begin
      send_byte(seq[i], o, kva, wc);
      model_byte(seq[i]);
      if (o.kv) ev++;
      n_vec++;
      if (o !== m) begin n_err++; $display("FAIL protocol byte %0d got %h want %h", i, o, m); end
    end
    n_vec++;
    if (proto_err !== 1'b1 || ev != 1 || press_count !== 8'd0)
      begin n_err++; $display("FAIL protocol_final got perr=%b events=%0d cnt=%h want 1 1 00", proto_err, ev, press_count); end
  endtask

  task automatic test_count_wrap();
    obs_t o; logic kva; int wc; logic [7:0] c;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] seq [5];
      int n;
      c = 8'h01 + 8'(i % 96);
      if (i[0]) begin seq = '{8'hE0, c, 8'hE0, 8'hF0, c}; n = 5; end
      else      begin seq = '{c, 8'hF0, c, 8'h00, 8'h00}; n = 3; end
      for (int j = 0; j < n; j++) begin
        send_byte(seq[j], o, kva, wc);
        model_byte(seq[j]);
        n_vec++;
        if (o !== m) begin n_err++; $display("FAIL wrap pair %0d byte %0d got %h want %h", i, j, o, m); end
      end
    end
    n_vec++;
    if (press_count !== 8'h00) begin n_err++; $display("FAIL wrap_final got %h want 00", press_count); end
  endtask

  task automatic test_random();
    logic [7:0] codes [4] = '{8'h1C, 8'h1B, 8'h75, 8'h29};
    logic [7:0] prot  [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    obs_t o; logic kva; int wc; logic [7:0] b; int r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 11));
      if (r == 0)      b = 8'hE0;
      else if (r <= 2) b = 8'hF0;
      else if (r == 3) b = prot[$urandom_range(0, 5)];
      else if (r == 4) b = 8'($urandom);
      else             b = codes[$urandom_range(0, 3)];
      repeat ($urandom_range(0, 2)) @(negedge clock);
      send_byte(b, o, kva, wc);
      model_byte(b);
      n_vec++;
      if (o !== m) begin n_err++; $display("FAIL random %0d byte %h got %h want %h", i, b, o, m); end
      n_vec++;
      if (kva !== 1'b0) begin n_err++; $display("FAIL random_pulse %0d got %b want 0", i, kva); end
      n_vec++;
      if (wc != 1) begin n_err++; $display("FAIL random_latency %0d got %0d want 1", i, wc); end
    end
  endtask

  task automatic test_reset_in_pop_and_ovf();
    obs_t zero = '0;
    obs_t o; logic kva; int wc = 0;
    do_reset();
    ps2_data = 8'h1C; ps2_ready = 1'b1;
    do begin @(negedge clock); wc++; end while (nextdata_n !== 1'b0 && wc < 20);
    n_vec++;
    if (wc >= 20) begin n_err++; $display("FAIL pop_timeout got %0d cycles want <20", wc); end
    reset = 1'b1; ps2_ready = 1'b0;
    @(negedge clock);
    n_vec++;
    if (nextdata_n !== 1'b1) begin n_err++; $display("FAIL reset_pop_nextdata_n got %b want 1", nextdata_n); end
    n_vec++;
    if (snap() !== zero) begin n_err++; $display("FAIL reset_pop_outputs got %h want %h", snap(), zero); end
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    ps2_overflow = 1'b1;
    @(negedge clock);
    ps2_overflow = 1'b0;
    m.ovf = 1'b1;
    n_vec++;
    if (ovf_seen !== 1'b1) begin n_err++; $display("FAIL ovf_latch got %b want 1", ovf_seen); end
    repeat (5) @(negedge clock);
    send_byte(8'h23, o, kva, wc);
    model_byte(8'h23);
    n_vec++;
    if (o !== m) begin n_err++; $display("FAIL ovf_keeps_popping got %h want %h", o, m); end
    do_reset();
    n_vec++;
    if (ovf_seen !== 1'b0) begin n_err++; $display("FAIL ovf_cleared got %b want 0", ovf_seen); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_make_break();
    test_extended();
    test_typematic();
    test_protocol();
    test_count_wrap();
    test_random();
    test_reset_in_pop_and_ovf();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
